// File: rtl/cam_capture_writer.sv
// cam_capture_writer
//   Write side of the camera frame buffer. Samples the OV7670 parallel bus
//   (pclk/href/vsync/data) in the clk domain and packs byte pairs into RGB565
//   words. Each complete pixel becomes one write to the buffer RAM, in raster
//   order.
// Ports
//   clk, rst         system clock (>= 4x cam_pclk), synchronous active-high reset
//   enable           arm capture of the next full frame; 0 stops at frame boundary
//   cam_pclk/href/vsync/data   asynchronous camera bus, sampled as data
//   addr_in/data_in/regwrite   buffer write port (one-cycle strobe per pixel)
//   frame_done       one-cycle pulse when a captured frame closes
//   pair_err         sticky flag: a line ended on an odd byte; cleared at frame start
module cam_capture_writer #(
  parameter int AW    = 17,
  parameter int DW    = 16,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          cam_pclk,
  input  logic          cam_href,
  input  logic          cam_vsync,
  input  logic [7:0]    cam_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          pair_err
);

  localparam logic [AW-1:0] TOTAL = AW'(IMG_W * IMG_H);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;
  state_t state, state_nxt;

  // Bit 0/1 are the two synchronizer flops, bit 2 is the edge-detect stage.
  // Data follows the same three stages so the byte lines up with rise_r.
  logic [2:0] pclk_sr, href_sr, vsync_sr;
  logic [7:0] data_s1, data_s2, data_d;
  logic       rise_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_sr  <= '0;
      href_sr  <= '0;
      vsync_sr <= '0;
      data_s1  <= '0;
      data_s2  <= '0;
      data_d   <= '0;
      rise_r   <= 1'b0;
    end else begin
      pclk_sr  <= {pclk_sr[1:0], cam_pclk};
      href_sr  <= {href_sr[1:0], cam_href};
      vsync_sr <= {vsync_sr[1:0], cam_vsync};
      data_s1  <= cam_data;
      data_s2  <= data_s1;
      data_d   <= data_s2;
      rise_r   <= pclk_sr[1] & ~pclk_sr[2];
    end
  end

  logic href_fall, vs_fall, vs_rise;
  assign href_fall = href_sr[2] & ~href_sr[1];
  assign vs_fall   = vsync_sr[2] & ~vsync_sr[1];
  assign vs_rise   = ~vsync_sr[2] & vsync_sr[1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  logic frame_start;

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    unique case (state)
      IDLE:    if (enable) state_nxt = WAIT_VS;
      WAIT_VS: begin
        if (!enable) state_nxt = IDLE;
        else if (vs_fall) begin
          state_nxt   = CAPTURE;
          frame_start = 1'b1;
        end
      end
      // enable is deliberately not looked at here: a started frame always completes
      CAPTURE: if (vs_rise) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = enable ? WAIT_VS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // phase_lo = 0 expects the high byte, 1 expects the low byte
  logic          phase_lo;
  logic          take, phase_tog, line_err;
  logic [AW-1:0] count;

  always_comb begin
    take      = (state == CAPTURE) && rise_r && href_sr[2];
    phase_tog = phase_lo ^ take;
    // Evaluate against the phase after any byte taken this cycle, so a byte and
    // an href fall landing together are still judged correctly.
    line_err  = (state == CAPTURE) && href_fall && phase_tog;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_in  <= '0;
      data_in  <= '0;
      regwrite <= 1'b0;
      pair_err <= 1'b0;
      phase_lo <= 1'b0;
      count    <= '0;
    end else begin
      regwrite <= 1'b0;
      if (frame_start) begin
        count    <= '0;
        pair_err <= 1'b0;
        phase_lo <= 1'b0;
      end else begin
        if (take) begin
          if (!phase_lo) data_in[15:8] <= data_d;
          else begin
            data_in[7:0] <= data_d;
            // Pixels beyond the frame size are dropped; address stays at the last pixel.
            if (count < TOTAL) begin
              regwrite <= 1'b1;
              addr_in  <= count;
              count    <= count + 1'b1;
            end
          end
        end
        // The dangling high byte is discarded by realigning to HI.
        if (line_err) begin
          pair_err <= 1'b1;
          phase_lo <= 1'b0;
        end else begin
          phase_lo <= phase_tog;
        end
      end
    end
  end

endmodule
